// File: rtl/axi_uart_tx_pkg.sv
// Shared 8N1 UART definitions: state encodings, frame width and the default
// baud divisor. The transmit and receive paths both import this package.
package axi_uart_tx_pkg;

   localparam int DATA_BITS            = 8;
   localparam int CLKS_PER_BIT_DEFAULT = 347;

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      START = 3'b001,
      DATA  = 3'b010,
      STOP  = 3'b011
   } uart_state_t;

endpackage

// File: rtl/axi_uart_tx_fifo.sv
// Small flop-based byte FIFO. The head entry is presented combinationally.
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 4,
   parameter int WIDTH      = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              head,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

   logic [WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Depth is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of the serializer.
// The serial line is registered so it never glitches.
module axi_uart_tx
   import axi_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          i_Clock,
   input  logic                          i_Rst_L,
   input  logic                          i_TX_Valid,
   input  logic [7:0]                    i_TX_Byte,
   output logic                          o_TX_Ready,
   output logic                          o_TX_Serial,
   output logic                          o_TX_Active,
   output logic                          o_TX_Done,
   output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

   uart_state_t          state;
   uart_state_t          state_next;
   logic [CW-1:0]        clk_cnt;
   logic [CW-1:0]        clk_cnt_next;
   logic [2:0]           bit_idx;
   logic [2:0]           bit_idx_next;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_next;
   logic [DATA_BITS-1:0] head;
   logic                 serial_next;
   logic                 done_next;
   logic                 pop;
   logic                 full;
   logic                 empty;

   uart_tx_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (DATA_BITS)
   ) u_fifo (
      .clk       (i_Clock),
      .rst_n     (i_Rst_L),
      .push      (i_TX_Valid),
      .push_data (i_TX_Byte),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (o_FIFO_Count)
   );

   assign o_TX_Ready  = !full;
   assign o_TX_Active = (state == START) || (state == DATA) || (state == STOP);

   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state       <= IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         o_TX_Serial <= 1'b1;
         o_TX_Done   <= 1'b0;
      end else begin
         state       <= state_next;
         clk_cnt     <= clk_cnt_next;
         bit_idx     <= bit_idx_next;
         shift       <= shift_next;
         o_TX_Serial <= serial_next;
         o_TX_Done   <= done_next;
      end
   end

   // serial_next is the level the line takes after this edge, so each state
   // also decides the first level of the state it hands over to.
   always_comb begin
      state_next   = state;
      clk_cnt_next = clk_cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift;
      serial_next  = 1'b1;
      done_next    = 1'b0;
      pop          = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop          = 1'b1;
               shift_next   = head;
               clk_cnt_next = '0;
               state_next   = START;
               serial_next  = 1'b0;
            end
         end
         START: begin
            serial_next = 1'b0;
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_next = '0;
               bit_idx_next = '0;
               state_next   = DATA;
               serial_next  = shift[0];
            end else begin
               clk_cnt_next = clk_cnt + CW'(1);
            end
         end
         DATA: begin
            serial_next = shift[bit_idx];
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_next = '0;
               if (bit_idx == BIT_LAST) begin
                  state_next  = STOP;
                  serial_next = 1'b1;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  serial_next  = shift[bit_idx + 3'd1];
               end
            end else begin
               clk_cnt_next = clk_cnt + CW'(1);
            end
         end
         STOP: begin
            serial_next = 1'b1;
            if (clk_cnt == CNT_LAST) begin
               clk_cnt_next = '0;
               done_next    = 1'b1;
               state_next   = IDLE;
            end else begin
               clk_cnt_next = clk_cnt + CW'(1);
            end
         end
         default: begin
            state_next  = IDLE;
            serial_next = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_uart_tx.sv
// Directed bench for axi_uart_tx: a line-decoding monitor checks every frame
// against a scoreboard of accepted bytes, plus timing and reset checks.
module tb_axi_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       tx_ready;
   logic       tx_serial;
   logic       tx_active;
   logic       tx_done;
   logic [2:0] fifo_count;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int last_acc_cyc = 0;
   int rst_epoch = 0;
   int frames_ok = 0;
   int done_total = 0;
   logic [7:0] exp_q[$];
   int start_q[$];
   int done_q[$];
   int ready_tab [6] = '{1, 1, 1, 1, 0, 0};
   int count_tab [6] = '{1, 1, 2, 3, 4, 4};

   axi_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .i_Clock      (clk),
      .i_Rst_L      (rst_n),
      .i_TX_Valid   (tx_valid),
      .i_TX_Byte    (tx_byte),
      .o_TX_Ready   (tx_ready),
      .o_TX_Serial  (tx_serial),
      .o_TX_Active  (tx_active),
      .o_TX_Done    (tx_done),
      .o_FIFO_Count (fifo_count)
   );

   always #5 clk = ~clk;

   // Edge counter and scoreboard capture of every accepted byte.
   always @(posedge clk) begin
      cyc++;
      if (rst_n && tx_valid && tx_ready) begin
         exp_q.push_back(tx_byte);
         acc_cnt++;
         last_acc_cyc = cyc;
      end
   end

   always @(negedge rst_n) rst_epoch++;

   always @(negedge clk) begin
      if (tx_done) begin
         done_total++;
         done_q.push_back(cyc);
      end
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_idle(input int max_cycles, input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || tx_active || fifo_count != 0) && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check_output({tag, "_drain"}, 32'(n < max_cycles), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic apply_stimulus(input logic [7:0] b);
      tx_valid = 1'b1;
      tx_byte  = b;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // Line monitor: samples mid-bit from the first low level seen.
   initial begin : monitor
      logic [7:0] data;
      logic       start_ok, stop_ok, act_ok, done_early, done_ok;
      int         ep;
      forever begin
         @(negedge clk);
         if (rst_n && !tx_serial) begin
            ep = rst_epoch;
            start_q.push_back(cyc);
            act_ok = tx_active;
            repeat (CPB/2) @(negedge clk);
            start_ok = !tx_serial;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               data[i] = tx_serial;
            end
            repeat (CPB) @(negedge clk);
            stop_ok = tx_serial;
            repeat (CPB - CPB/2 - 1) @(negedge clk);
            done_early = tx_done;
            act_ok = act_ok && tx_active;
            @(negedge clk);
            done_ok = tx_done && !tx_active;
            if (ep == rst_epoch) begin
               check_output("start_bit", 32'(start_ok), 32'd1);
               check_output("stop_bit", 32'(stop_ok), 32'd1);
               check_output("active_span", 32'(act_ok && !done_early), 32'd1);
               check_output("done_at_40", 32'(done_ok), 32'd1);
               if (exp_q.size() == 0) begin
                  check_output("frame_unexpected", 32'(data), 32'hFFFF_FFFF);
               end else begin
                  check_output("frame_data", 32'(data), 32'(exp_q.pop_front()));
               end
               frames_ok++;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("[TB] FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : stimulus
      int e1, s0, f0, d0, low_cnt, n;
      #12;
      check_output("rst_serial", 32'(tx_serial), 32'd1);
      check_output("rst_active", 32'(tx_active), 32'd0);
      check_output("rst_done", 32'(tx_done), 32'd0);
      check_output("rst_count", 32'(fifo_count), 32'd0);
      check_output("rst_ready", 32'(tx_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] single frame 0xA5");
      apply_stimulus(8'hA5);
      check_output("t1_count_after_push", 32'(fifo_count), 32'd1);
      check_output("t1_idle_line", 32'(tx_serial), 32'd1);
      @(negedge clk);
      check_output("t1_count_after_pop", 32'(fifo_count), 32'd0);
      check_output("t1_start_latency", 32'(start_q[$]), 32'(last_acc_cyc + 1));
      wait_idle(200, "t1");
      check_output("t1_done_cycle", 32'(done_q[$]), 32'(start_q[$] + 10*CPB));

      $display("[TB] burst of six into a four-deep FIFO");
      for (int i = 0; i < 6; i++) begin
         tx_valid = 1'b1;
         tx_byte  = 8'h10 + 8'(i);
         @(negedge clk);
         if (i == 0) e1 = last_acc_cyc;
         check_output($sformatf("t2_ready_%0d", i), 32'(tx_ready), 32'(ready_tab[i]));
         check_output($sformatf("t2_count_%0d", i), 32'(fifo_count), 32'(count_tab[i]));
      end
      check_output("t2_accepted_five", 32'(exp_q.size() + 1), 32'd6);
      n = 0;
      while (exp_q[$] != 8'h15 && n < 100) begin
         @(negedge clk);
         n++;
      end
      tx_valid = 1'b0;
      check_output("t2_late_accept_edge", 32'(last_acc_cyc), 32'(e1 + 43));

      $display("[TB] full FIFO ignores pushes");
      check_output("t4_full_count", 32'(fifo_count), 32'd4);
      check_output("t4_full_ready", 32'(tx_ready), 32'd0);
      s0 = acc_cnt;
      tx_valid = 1'b1;
      tx_byte  = 8'hEE;
      repeat (5) @(negedge clk);
      tx_valid = 1'b0;
      check_output("t4_push_ignored", 32'(acc_cnt), 32'(s0));
      check_output("t4_still_full", 32'(fifo_count), 32'd4);
      n = 0;
      while (fifo_count == 3'd4 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_output("t4_pop_edge", 32'(cyc), 32'(e1 + 83));
      check_output("t4_count_after_pop", 32'(fifo_count), 32'd3);
      wait_idle(400, "t2");

      $display("[TB] back-to-back 0x00, 0xFF");
      tx_valid = 1'b1;
      tx_byte  = 8'h00;
      @(negedge clk);
      tx_byte  = 8'hFF;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_idle(200, "t3");
      check_output("t3_start_gap", 32'(start_q[$] - start_q[$-1]), 32'(10*CPB + 1));
      check_output("t3_done_gap", 32'(done_q[$] - done_q[$-1]), 32'(10*CPB + 1));

      $display("[TB] reset during data bit 3");
      tx_valid = 1'b1;
      tx_byte  = 8'h35;
      @(negedge clk);
      tx_byte  = 8'h77;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (17) @(negedge clk);
      check_output("t5_bit3_low", 32'(tx_serial), 32'd0);
      check_output("t5_count_pre", 32'(fifo_count), 32'd1);
      f0 = start_q.size();
      d0 = done_total;
      #2;
      rst_n = 1'b0;
      #1;
      check_output("t5_async_serial", 32'(tx_serial), 32'd1);
      check_output("t5_async_count", 32'(fifo_count), 32'd0);
      check_output("t5_async_active", 32'(tx_active), 32'd0);
      check_output("t5_async_done", 32'(tx_done), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      low_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!tx_serial || tx_active) low_cnt++;
      end
      check_output("t5_line_quiet", 32'(low_cnt), 32'd0);
      check_output("t5_no_stale_frame", 32'(start_q.size()), 32'(f0));
      check_output("t5_no_done", 32'(done_total), 32'(d0));

      $display("[TB] stream 0x00..0xFF");
      s0 = frames_ok;
      d0 = done_total;
      for (int b = 0; b < 256; b++) begin
         tx_valid = 1'b1;
         tx_byte  = 8'(b);
         e1 = acc_cnt;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (acc_cnt == e1 && n < 200);
         if (acc_cnt == e1) begin
            check_output("t6_accept_timeout", 32'(b), 32'hFFFF_FFFF);
            break;
         end
      end
      tx_valid = 1'b0;
      wait_idle(1000, "t6");
      check_output("t6_frames", 32'(frames_ok - s0), 32'd256);
      check_output("t6_dones", 32'(done_total - d0), 32'd256);
      check_output("final_done_per_frame", 32'(done_total), 32'(frames_ok));
      check_output("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
